// File: rtl/fpu_ret_collect.sv
// fpu_ret_collect: per-lane completion FIFOs for FPU lanes u1/u3/u5,
// retiring up to two completions per cycle to the ROB, round-robin.
// Ports: clk, rst (sync, active high), flush; uN_ret/_en/_id pushes;
// uN_stall back-pressure; out_rdy ack; retN_en/data/id/lane; err_ovf.
module fpu_ret_collect #(
  parameter int DEPTH        = 4,
  parameter int STALL_MARGIN = 2,
  parameter int ID_W         = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [13:0]     u1_ret,
  input  logic            u1_ret_en,
  input  logic [ID_W-1:0] u1_ret_id,
  input  logic [13:0]     u3_ret,
  input  logic            u3_ret_en,
  input  logic [ID_W-1:0] u3_ret_id,
  input  logic [13:0]     u5_ret,
  input  logic            u5_ret_en,
  input  logic [ID_W-1:0] u5_ret_id,
  output logic            u1_stall,
  output logic            u3_stall,
  output logic            u5_stall,
  input  logic            out_rdy,
  output logic            ret0_en,
  output logic            ret1_en,
  output logic [13:0]     ret0_data,
  output logic [13:0]     ret1_data,
  output logic [ID_W-1:0] ret0_id,
  output logic [ID_W-1:0] ret1_id,
  output logic [1:0]      ret0_lane,
  output logic [1:0]      ret1_lane,
  output logic            err_ovf
);

  localparam int NL = 3;
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 14 + ID_W;
  localparam logic [AW:0] FULL_CNT =
    (AW+1)'(DEPTH);
  localparam logic [AW:0] STALL_TH =
    (AW+1)'(DEPTH - STALL_MARGIN);

  logic [NL-1:0] push;
  logic [EW-1:0] push_ent [NL];

  logic [EW-1:0] mem [NL][DEPTH];
  logic [AW-1:0] head_q [NL];
  logic [AW-1:0] tail_q [NL];
  logic [AW:0]   cnt_q [NL];
  logic [AW:0]   cnt_nxt [NL];
  logic [EW-1:0] head_ent [NL];

  logic [NL-1:0] nempty;
  logic [NL-1:0] full;
  logic [NL-1:0] pop;
  logic [NL-1:0] wr;
  logic [NL-1:0] drop;

  logic [1:0] rr_q;
  logic [1:0] rr_nxt;
  logic [1:0] lst;
  logic [1:0] ord [NL];

  logic       p0_v;
  logic       p1_v;
  logic [1:0] p0_l;
  logic [1:0] p1_l;

  logic          ovf_q;
  logic [NL-1:0] stall_q;

  assign push = {u5_ret_en, u3_ret_en, u1_ret_en};
  assign push_ent[0] = {u1_ret, u1_ret_id};
  assign push_ent[1] = {u3_ret, u3_ret_id};
  assign push_ent[2] = {u5_ret, u5_ret_id};

  always_comb begin
    for (int i = 0; i < NL; i++) begin
      head_ent[i] = mem[i][head_q[i]];
      nempty[i]   = cnt_q[i] != '0;
      full[i]     = cnt_q[i] == FULL_CNT;
    end
  end

  // Scan order starting at rr, wrapping mod 3.
  always_comb begin
    case (rr_q)
      2'd1: begin
        ord[0] = 2'd1;
        ord[1] = 2'd2;
        ord[2] = 2'd0;
      end
      2'd2: begin
        ord[0] = 2'd2;
        ord[1] = 2'd0;
        ord[2] = 2'd1;
      end
      default: begin
        ord[0] = 2'd0;
        ord[1] = 2'd1;
        ord[2] = 2'd2;
      end
    endcase
  end

  // First non-empty lane in scan order gets
  // port 0, the second gets port 1.
  always_comb begin
    p0_v = 1'b0;
    p0_l = 2'd0;
    p1_v = 1'b0;
    p1_l = 2'd0;
    for (int k = 0; k < NL; k++) begin
      if (nempty[ord[k]]) begin
        if (!p0_v) begin
          p0_v = 1'b1;
          p0_l = ord[k];
        end else if (!p1_v) begin
          p1_v = 1'b1;
          p1_l = ord[k];
        end
      end
    end
  end

  // A pop in the same cycle frees a slot,
  // so a push to a full lane still lands.
  always_comb begin
    for (int i = 0; i < NL; i++) begin
      pop[i] = out_rdy &
        ((p0_v & (p0_l == 2'(i))) |
         (p1_v & (p1_l == 2'(i))));
      wr[i]   = push[i] & (~full[i] | pop[i]);
      drop[i] = push[i] & full[i] & ~pop[i];
      if (flush)
        cnt_nxt[i] = '0;
      else
        cnt_nxt[i] = cnt_q[i]
          + (AW+1)'(wr[i])
          - (AW+1)'(pop[i]);
    end
  end

  always_comb begin
    rr_nxt = rr_q;
    lst    = p1_v ? p1_l : p0_l;
    if (flush)
      rr_nxt = 2'd0;
    else if (|pop)
      rr_nxt = (lst == 2'd2) ? 2'd0 : lst + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NL; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      rr_q    <= 2'd0;
      ovf_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      rr_q <= rr_nxt;
      if (!flush && (|drop))
        ovf_q <= 1'b1;
      for (int i = 0; i < NL; i++) begin
        cnt_q[i]   <= cnt_nxt[i];
        stall_q[i] <= cnt_nxt[i] >= STALL_TH;
        if (flush) begin
          head_q[i] <= '0;
          tail_q[i] <= '0;
        end else begin
          if (pop[i])
            head_q[i] <= head_q[i] + AW'(1);
          if (wr[i])
            tail_q[i] <= tail_q[i] + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (!rst && !flush && wr[i])
        mem[i][tail_q[i]] <= push_ent[i];
    end
  end

  assign ret0_en   = p0_v;
  assign ret0_lane = p0_v ? p0_l : 2'd0;
  assign ret0_data = p0_v ?
    head_ent[p0_l][EW-1:ID_W] : '0;
  assign ret0_id   = p0_v ?
    head_ent[p0_l][ID_W-1:0] : '0;

  assign ret1_en   = p1_v;
  assign ret1_lane = p1_v ? p1_l : 2'd0;
  assign ret1_data = p1_v ?
    head_ent[p1_l][EW-1:ID_W] : '0;
  assign ret1_id   = p1_v ?
    head_ent[p1_l][ID_W-1:0] : '0;

  assign u1_stall = stall_q[0];
  assign u3_stall = stall_q[1];
  assign u5_stall = stall_q[2];
  assign err_ovf  = ovf_q;

endmodule

// File: doc/fpu_ret_collect.md
Name: fpu_ret_collect

Overview:
- Receiving end of the FPU completion interface (`uN_ret` / `uN_ret_en`) driven by the three FPU lanes u1, u3 and u5.
- Buffers each lane's 14-bit completion status and its ROB slot id in a per-lane FIFO.
- Arbitrates up to two completions per cycle onto the retire write-back ports.
- Returns per-lane stall back-pressure to the FPU scheduler.
- Sits between the FPU lane cluster and the ROB completion write ports.

Parameters:
- DEPTH, 4, entries per lane FIFO (power of two, at least 4).
- STALL_MARGIN, 2, free-entry margin covering issue-to-return pipeline slack.
- ID_W, 9, ROB slot id width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flush  input  1  pipeline flush; discards all buffered completions
- u1_ret  input  14  lane 0 completion status/exception flags
- u1_ret_en  input  1  lane 0 completion valid
- u1_ret_id  input  ID_W  lane 0 ROB slot id
- u3_ret, u3_ret_en, u3_ret_id  input  14/1/ID_W  lane 1, same meaning as lane 0
- u5_ret, u5_ret_en, u5_ret_id  input  14/1/ID_W  lane 2, same meaning as lane 0
- u1_stall, u3_stall, u5_stall  output  1  per-lane "stop issuing" back-pressure
- out_rdy  input  1  ROB accepts both write-back ports this cycle
- ret0_en, ret1_en  output  1  write-back port valid
- ret0_data, ret1_data  output  14  status
- ret0_id, ret1_id  output  ID_W  ROB slot
- ret0_lane, ret1_lane  output  2  source lane (0, 1, 2)
- err_ovf  output  1  sticky: a push arrived at a full FIFO

Behaviour:
- Reset (rst high at the clock edge):
  - all FIFOs empty, counts 0;
  - round-robin pointer rr = 0;
  - err_ovf = 0;
  - all retN_en = 0; retN_data, retN_id and retN_lane = 0;
  - stalls = 0.
  - rst has priority over flush, pushes and pops.
- Push:
  - On uN_ret_en, {ret, id} is written at the lane's tail on the clock edge.
  - The entry is visible at the outputs no earlier than the next cycle. There is no bypass, so minimum latency is 1 cycle.
- Outputs:
  - Combinational from the FIFO heads and rr.
  - Starting at lane rr and scanning rr, rr+1, rr+2 mod 3, the first non-empty lane drives port 0 and the second drives port 1.
  - A port with no lane assigned has en = 0 and data, id and lane = 0.
- Pop:
  - Occurs only when out_rdy = 1. Each granted lane pops exactly one entry.
  - When out_rdy = 0, nothing pops and the outputs hold their values, given no new pushes change the head selection.
  - The ROB must tolerate the en/data of an un-acked port changing only through a new arrival.
- rr update:
  - On any pop, rr becomes (last granted lane + 1) mod 3.
  - Otherwise rr is unchanged.
- Same-lane push and pop in one cycle: both happen and the count is unchanged. This holds even when the FIFO is full, because the pop frees the slot first.
- Overflow:
  - A push to a full FIFO with no simultaneous pop is dropped.
  - err_ovf is set and stays set until rst; flush does not clear it.
- Wrap-around: head and tail pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.
- Stall: uN_stall = registered (count_next >= DEPTH - STALL_MARGIN). It updates one cycle after the count change.
- Flush:
  - Empties all FIFOs and sets rr = 0. Stall deasserts on the next cycle.
  - Pushes and pops in the flush cycle are discarded.
  - Outputs are 0 in the cycle after the flush.
- Ordering: within one lane, completions leave in arrival order. There is no ordering guarantee across lanes.

Test Plan:
- Reset mid-traffic:
  - Stimulus: fill lane 0 with 3 entries, then assert rst for 1 cycle.
  - Required response: next cycle ret0_en = ret1_en = 0, all stalls 0, err_ovf 0.
- Single completion:
  - Stimulus: u3_ret = 14'h0A5, u3_ret_id = 9'd17, en for 1 cycle, out_rdy = 1.
  - Required response: next cycle ret0_en = 1, ret0_data = 0A5, ret0_id = 17, ret0_lane = 1, ret1_en = 0. One cycle later all outputs are 0.
- Three-way arbitration:
  - Stimulus: all three lanes push in one cycle, ids 1, 2, 3; rr = 0; out_rdy = 1.
  - Required response: cycle +1, port0 = id 1 (lane 0) and port1 = id 2 (lane 1), and rr becomes 2. Cycle +2, port0 = id 3 (lane 2), and rr becomes 0.
- Back-pressure and stall:
  - Stimulus: out_rdy = 0, push lane 2 on four consecutive cycles.
  - Required response: u5_stall = 1 starting the cycle after the 2nd push.
  - Stimulus: a 5th push.
  - Required response: dropped, err_ovf = 1.
  - Stimulus: raise out_rdy.
  - Required response: ids drain in order over 4 cycles; u5_stall clears once count < 2.
- Full with simultaneous push and pop:
  - Stimulus: lane 0 full, out_rdy = 1, push id 9.
  - Required response: count stays 4, err_ovf stays 0, id 9 emerges last.
- Flush:
  - Stimulus: assert flush with entries in all lanes and a concurrent push.
  - Required response: next cycle no ret*_en, stalls 0, err_ovf unchanged, and the concurrent push never appears.
